multi_cycle_alu: RTL and testbench
==================================

# multi_cycle_alu

Parametrised start/done ALU that succeeds the fixed 8-bit single-cycle add/and/xor unit. It adds generic operand width, a multi-cycle multiply with configurable latency, a busy indication, and an error pulse for illegal opcodes. It sits behind the testbench/host driver as the datapath DUT and is driven with a start/done handshake.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- MUL_LATENCY, 3, cycles from multiply accept to done; must be ≥ 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- op_code  input  3  000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101–111 illegal.
- start  input  1  request; sampled only while idle.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- err  output  1  one-cycle pulse on an illegal opcode accept.
- result  output  2*WIDTH  last completed result, held until the next done.

## Operation
- State machine: IDLE, BUSY.
- IDLE, start=1, legal op_code:
  - Accept the operation.
  - Register A, B and op_code.
  - Load the counter with the latency minus 1: 0 for no_op/add/and/xor, MUL_LATENCY-1 for mul.
  - Go to BUSY.
- IDLE, start=1, illegal op_code:
  - Pulse err next cycle.
  - Stay in IDLE; no done.
  - result unchanged.
- IDLE, start=0: hold.
- BUSY, counter>0: decrement the counter; start and input changes are ignored.
- BUSY, counter==0:
  - Register result, pulse done next cycle, return to IDLE.
  - busy drops in the same cycle that done rises.
- Result width rules:
  - add: zero-extended WIDTH+1-bit sum, carry in bit WIDTH.
  - and/xor: zero-extended to 2*WIDTH.
  - mul: full unsigned 2*WIDTH product of the captured operands.
  - no_op: result unchanged, done still pulses.
- Back-to-back: start may be high in the done cycle (IDLE). It is accepted there, so single-cycle ops complete every 2 cycles.
- Operands are captured at accept. Changing A/B/op_code while busy does not affect the in-flight operation.
- done and err are never high in the same cycle.

## Timing
- Reset values: busy=0, done=0, err=0, result=0; state IDLE; counter=0.
- Reset asserted mid-operation:
  - Aborts immediately (asynchronous).
  - No done, ever, for the aborted operation.
  - result returns to 0.
- After reset deasserts, the first rising edge with start=1 is an accept.
- Accept at edge k: busy=1 after edge k.
- no_op/add/and/xor: done=1 after edge k+1, for one cycle.
- mul: done=1 after edge k+MUL_LATENCY. With MUL_LATENCY=1, mul timing is identical to add.
- Illegal opcode at edge k: err=1 after edge k+1 for one cycle; busy stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- alu_pkg holds:
  - op_t enum: NO_OP, ADD, AND, XOR, MUL.
  - state_t enum: IDLE, BUSY.
  - helper function is_legal_op(op_t).
- A latency counter of width $clog2(MUL_LATENCY+1) is inline in the FSM.
- No sub-module is required. The multiply is computed from the captured operands and registered at the terminal count, so synthesis may retime it across the MUL_LATENCY cycles.

## Test plan
All scenarios use WIDTH=8, MUL_LATENCY=3.
- Reset then idle: reset pulse, start=0 for 5 cycles -> busy/done/err/result all 0 throughout.
- add 0xFF+0x01, start one cycle -> done one cycle later, result=0x0100, busy high exactly 1 cycle.
- mul 0xFF*0xFF -> done 3 cycles after accept, result=0xFE01; A/B changed to 0x00 while busy must not alter the result.
- Back-to-back with start held high: xor 0xF0^0x3C then and 0xF0&0x3C -> result 0x00CC at the first done, 0x0030 at the second done 2 cycles later.
- Illegal op_code 3'b110 with A=0x12 -> err pulse after 1 cycle, no done, result keeps the previous value; a subsequent no_op gives done with result unchanged.
- Reset asserted 1 cycle into mul 0x10*0x10 -> outputs 0 immediately, no done after release; a new add 0x01+0x02 then returns 0x0003.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state encodings,
// plus the opcode legality check used at accept time.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      NO_OP = 3'b000,
      ADD   = 3'b001,
      AND   = 3'b010,
      XOR   = 3'b011,
      MUL   = 3'b100
   } op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Codes 101-111 have no operation behind them and raise err instead.
   function automatic logic is_legal_op(op_t op);
      logic legal;
      case (op)
         NO_OP, ADD, AND, XOR, MUL: legal = 1'b1;
         default:                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/multi_cycle_alu.sv
// Start/done ALU with parametrised operand width and a multi-cycle multiply.
// Operands and opcode are captured on accept; the result is computed from the
// captured copies and registered at the terminal count, so every output is a
// flop and input changes while busy cannot disturb the in-flight operation.
module multi_cycle_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           op_code,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2*WIDTH-1:0]   result
);

   localparam int unsigned       CNT_W    = $clog2(MUL_LATENCY + 1);
   localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     a_q, b_q;
   op_t                  op_q;
   op_t                  op_in;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 done_q;
   logic                 err_pend_q, err_q;
   logic                 accept, illegal, finish;

   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   product;

   assign op_in   = op_t'(op_code);
   assign sum     = {1'b0, a_q} + {1'b0, b_q};
   assign product = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // State and latency counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: accept/reject in IDLE, count down in BUSY, finish at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      illegal = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_legal_op(op_in)) begin
                  accept  = 1'b1;
                  cnt_d   = (op_in == MUL) ? MUL_LOAD : '0;
                  state_d = BUSY;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Capture operands and opcode on accept only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= NO_OP;
      end else if (accept) begin
         a_q  <= A;
         b_q  <= B;
         op_q <= op_in;
      end
   end

   // Result selection from the captured operands; no_op keeps the old value.
   always_comb begin
      result_d = result_q;
      case (op_q)
         ADD:     result_d = {{(WIDTH-1){1'b0}}, sum};
         AND:     result_d = {{WIDTH{1'b0}}, a_q & b_q};
         XOR:     result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
         MUL:     result_d = product;
         default: result_d = result_q;
      endcase
   end

   // Registered outputs: result/done at terminal count, err one cycle late.
   // err goes through a pending stage so it lands one edge after the
   // rejected start, matching the done timing of a single-cycle op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q   <= '0;
         done_q     <= 1'b0;
         err_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q     <= finish;
         err_pend_q <= illegal;
         err_q      <= err_pend_q;
         if (finish) begin
            result_q <= result_d;
         end
      end
   end

   assign busy   = (state_q == BUSY);
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Bench for multi_cycle_alu (WIDTH=8, MUL_LATENCY=3): transaction-level model
// tracked in absolute edge numbers, a per-cycle compare against it, and
// directed scenarios with literal expectations.
module tb_multi_cycle_alu;

   localparam int MUL_LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  A, B;
   logic [2:0]  op_code;
   logic        start;
   logic        busy, done, err;
   logic [15:0] result;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   multi_cycle_alu #(.WIDTH(8), .MUL_LATENCY(MUL_LAT)) dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .op_code (op_code),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [15:0] prev);
      case (op)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return prev;
      endcase
   endfunction

   // Model: edge number cyc; an op accepted at edge k completes at edge
   // done_at = k + latency and occupies the unit until then.
   int          cyc      = 0;
   int          done_at  = -1;
   int          err_at   = -1;
   logic [15:0] exp_res  = '0;
   logic [15:0] pend_res = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         done_at <= -1;
         err_at  <= -1;
         exp_res <= '0;
      end else begin
         cyc <= cyc + 1;
         if (done_at == cyc + 1) exp_res <= pend_res;
         if (done_at < cyc + 1 && start) begin
            if (op_code <= 3'd4) begin
               done_at  <= cyc + 1 + ((op_code == 3'd4) ? MUL_LAT : 1);
               pend_res <= alu_ref(op_code, A, B, exp_res);
            end else begin
               err_at <= cyc + 2;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",   {31'b0, busy},   {31'b0, done_at > cyc});
         check("done",   {31'b0, done},   {31'b0, done_at == cyc});
         check("err",    {31'b0, err},    {31'b0, err_at == cyc});
         check("result", {16'b0, result}, {16'b0, exp_res});
         if (done && err) begin
            fails++;
            $display("FAIL done_err_overlap: done=%0b err=%0b required not both", done, err);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      A = a; B = b; op_code = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0; A = 8'h00; B = 8'h00; op_code = 3'b111;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         fails++;
         $display("FAIL done_timeout: no done within %0d cycles", lat);
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat, input logic [15:0] exp_r);
      int lat;
      issue(op, a, b);
      wait_done(lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_res"}, {16'b0, result}, {16'b0, exp_r});
   endtask

   initial begin
      int dcount;
      reset = 1'b0; start = 1'b0; A = '0; B = '0; op_code = '0;
      #1 reset = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_busy",   {31'b0, busy}, 32'd0);
         check("idle_result", {16'b0, result}, 32'd0);
      end

      run_op("add_ff_01", 3'b001, 8'hFF, 8'h01, 1, 16'h0100);
      run_op("add_7f_80", 3'b001, 8'h7F, 8'h80, 1, 16'h00FF);
      run_op("mul_ff_ff", 3'b100, 8'hFF, 8'hFF, 3, 16'hFE01);
      run_op("mul_12_34", 3'b100, 8'h12, 8'h34, 3, 16'h03A8);

      // back-to-back with start held high
      @(negedge clk);
      A = 8'hF0; B = 8'h3C; op_code = 3'b011; start = 1'b1;
      @(negedge clk);
      op_code = 3'b010;
      @(negedge clk);
      check("b2b_done1", {31'b0, done}, 32'd1);
      check("b2b_res1",  {16'b0, result}, 32'h00CC);
      @(negedge clk);
      start = 1'b0; op_code = 3'b111;
      check("b2b_busy2", {31'b0, busy}, 32'd1);
      @(negedge clk);
      check("b2b_done2", {31'b0, done}, 32'd1);
      check("b2b_res2",  {16'b0, result}, 32'h0030);

      // illegal opcode, then no_op
      issue(3'b110, 8'h12, 8'h00);
      check("ill_err_early", {31'b0, err}, 32'd0);
      @(negedge clk);
      check("ill_err",    {31'b0, err},  32'd1);
      check("ill_done",   {31'b0, done}, 32'd0);
      check("ill_busy",   {31'b0, busy}, 32'd0);
      check("ill_result", {16'b0, result}, 32'h0030);
      @(negedge clk);
      check("ill_err_end", {31'b0, err}, 32'd0);
      run_op("noop", 3'b000, 8'h55, 8'hAA, 1, 16'h0030);

      // reset one cycle into a multiply
      issue(3'b100, 8'h10, 8'h10);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_done",   {31'b0, done}, 32'd0);
      check("rst_result", {16'b0, result}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         dcount += int'(done);
      end
      check("rst_no_done", 32'(dcount), 32'd0);
      run_op("add_01_02", 3'b001, 8'h01, 8'h02, 1, 16'h0003);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
